pixel_packet_decoder: RTL
=========================

Name: pixel_packet_decoder

Overview:
- Receive-side decoder for the 24-bit image packet protocol carried over UART at 625 kbaud.
- Consumes the byte stream from the UART receiver and reassembles 3-byte packets, sent MSB byte first.
- Checks each packet's header, footer parity and location range.
- Issues one write per good packet into the pixel memory that feeds the NN CPU, and raises receive_done once a full 28x28 image has been accepted.

Parameters:
NUM_PIXELS, 784, packets (distinct valid writes) that make up one image; also the exclusive upper bound on loc
TIMEOUT_CYCLES, 4000, idle clocks allowed between bytes of one packet before resync (2.5 byte times at 100 MHz / 625 kbaud)
ERR_W, 16, width of the saturating error counter

Ports:
clk  input  1  system clock, 100 MHz
rst_n  input  1  asynchronous active-low reset
rx_byte  input  8  byte from UART receiver
rx_valid  input  1  one-cycle strobe, rx_byte valid
wr_en  output  1  one-cycle pixel write strobe
wr_addr  output  10  pixel location
wr_data  output  8  pixel value
pkt_err  output  1  one-cycle pulse per rejected packet
err_count  output  ERR_W  rejected packets, saturating
count_packets  output  32  accepted packets, wraps
receive_done  output  1  sticky, image complete

Behaviour:
- Clock and reset: clk is the only clock; rst_n is asynchronous and active-low.
- Reset values: all outputs 0; FSM to S_B0; shift registers cleared.
- Packet layout: bits[23:21] = 3'b101; [20:11] = loc; [10:3] = data; [2:0] = footer.
  - byte0 = {101, loc[9:5]}
  - byte1 = {loc[4:0], data[7:5]}
  - byte2 = {data[4:0], footer}
- Footer, computed on the reassembled fields:
  - f[2] = ^data
  - f[1] = ^loc
  - f[0] = ^{data[7:4], loc[9:5]}
- FSM states: S_B0, S_B1, S_B2, S_CHK.
  - S_B0: on rx_valid, if rx_byte[7:5] == 3'b101, latch the byte and go to S_B1. Otherwise drop the byte silently (no pkt_err, no count) and stay in S_B0. This is the resync path.
  - S_B1: on rx_valid, latch the byte and go to S_B2.
  - S_B2: on rx_valid, latch the byte and go to S_CHK.
  - S_CHK: one cycle. Evaluate footer match and loc < NUM_PIXELS.
    - Pass: wr_en = 1 with wr_addr/wr_data; count_packets += 1.
    - Fail: pkt_err = 1; err_count += 1, saturating at all-ones.
    - Always return to S_B0.
- rx_valid arriving while in S_CHK is not dropped: it is processed as a byte0 candidate in the same cycle.
- Latency: wr_en asserts exactly 1 clk after the rx_valid cycle of byte2. wr_addr/wr_data hold their value until the next write.
- Valid-pixel tracking:
  - A 10-bit counter of writes, saturating at NUM_PIXELS, drives receive_done.
  - receive_done rises in the same cycle as the wr_en of the NUM_PIXELS-th accepted packet.
  - receive_done stays high until rst_n.
  - Writes continue after receive_done (later packets overwrite pixels); the counter does not wrap.
- Duplicate locations count as separate accepts (no per-location bitmap).
- Reset mid-packet aborts the packet immediately: no write, no error.
- count_packets wraps at 2^32.

Optional Feature:
- Macro PKT_TIMEOUT_EN.
- Defined: a counter clears on every rx_valid and runs while the FSM is in S_B1 or S_B2. When it reaches TIMEOUT_CYCLES, the FSM returns to S_B0, pkt_err pulses once and err_count increments. Bytes already latched are discarded.
- Not defined: no timeout logic; a partial packet waits indefinitely for its remaining bytes.

Test Plan:
- Good packet: rx bytes A0,0C,07 (loc=1, data=0x80, footer=111) -> wr_en pulse 1 clk after 3rd strobe; wr_addr=1, wr_data=0x80; count_packets=1; pkt_err=0.
- Footer corruption: A0,0C,06 -> pkt_err pulse, err_count=1, no wr_en, count_packets unchanged.
- Header resync: 0x40 then A0,0C,07 -> 0x40 dropped with no error; single write loc=1, data=0x80; err_count=0.
- Range check: B9,00,03 (loc=800, data=0, footer=011, valid parity) -> pkt_err, err_count=1, no write.
- Full image: 784 packets, loc 0..783, data from X_q_data.mem, UART-paced -> 784 writes with matching addr/data; receive_done rises with the final wr_en; count_packets=784. A 785th packet still writes, and receive_done stays 1.
- Timeout (PKT_TIMEOUT_EN): A0,0C, idle 4000 clks, then 07 -> pkt_err at timeout; 07 dropped in S_B0; no write; err_count=1. Without the macro: no error, and A0,0C,07 writes loc=1.

Source files
------------

// File: rtl/pixel_packet_decoder.sv
// Reassembles 3-byte image packets from the UART byte stream, checks them, and writes good pixels.
// Optional packet timeout is compiled in with `define PKT_TIMEOUT_EN.
module pixel_packet_decoder #(
    parameter int NUM_PIXELS     = 784,
    parameter int TIMEOUT_CYCLES = 4000,
    parameter int ERR_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_byte,
    input  logic             rx_valid,
    output logic             wr_en,
    output logic [9:0]       wr_addr,
    output logic [7:0]       wr_data,
    output logic             pkt_err,
    output logic [ERR_W-1:0] err_count,
    output logic [31:0]      count_packets,
    output logic             receive_done
);

    // rx_valid is a single-cycle strobe with no back-pressure: a byte is consumed
    // in exactly the cycle its strobe is high, in whatever state the FSM is in.
    typedef enum logic [1:0] {
        S_B0  = 2'd0,
        S_B1  = 2'd1,
        S_B2  = 2'd2,
        S_CHK = 2'd3
    } state_t;

    localparam logic [9:0]  PIX_MAX   = 10'(NUM_PIXELS);
    localparam logic [10:0] LOC_LIMIT = 11'(NUM_PIXELS);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] byte0;
    logic [7:0] byte1;
    logic       take_b0;
    logic       take_b1;
    logic       take_b2;
    logic       timeout;
    logic [9:0] pix_cnt;

    logic [9:0] loc;
    logic [7:0] data;
    logic [2:0] footer;
    logic [2:0] footer_exp;
    logic       pkt_good;

    // The packet is judged as byte2 arrives so the result is registered and
    // presented during the S_CHK cycle, one clock after the byte2 strobe.
    assign loc        = {byte0[4:0], byte1[7:3]};
    assign data       = {byte1[2:0], rx_byte[7:3]};
    assign footer     = rx_byte[2:0];
    assign footer_exp = {^data, ^loc, ^{data[7:4], loc[9:5]}};
    assign pkt_good   = (footer == footer_exp) && ({1'b0, loc} < LOC_LIMIT);

`ifdef PKT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt;
    logic          mid_pkt;

    assign mid_pkt = (state == S_B1) || (state == S_B2);
    assign timeout = mid_pkt && !rx_valid && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (rx_valid || !mid_pkt || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    // Timeout disabled: a partial packet waits for its remaining bytes.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_B0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take_b0   = 1'b0;
        take_b1   = 1'b0;
        take_b2   = 1'b0;
        case (state)
            S_B0, S_CHK: begin
                state_nxt = S_B0;
                if (rx_valid && (rx_byte[7:5] == 3'b101)) begin
                    take_b0   = 1'b1;
                    state_nxt = S_B1;
                end
            end
            S_B1: begin
                if (timeout) begin
                    state_nxt = S_B0;
                end else if (rx_valid) begin
                    take_b1   = 1'b1;
                    state_nxt = S_B2;
                end
            end
            S_B2: begin
                if (timeout) begin
                    state_nxt = S_B0;
                end else if (rx_valid) begin
                    take_b2   = 1'b1;
                    state_nxt = S_CHK;
                end
            end
            default: state_nxt = S_B0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte0 <= '0;
            byte1 <= '0;
        end else begin
            if (take_b0) byte0 <= rx_byte;
            if (take_b1) byte1 <= rx_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            pkt_err       <= 1'b0;
            err_count     <= '0;
            count_packets <= '0;
            pix_cnt       <= '0;
            receive_done  <= 1'b0;
        end else begin
            wr_en   <= 1'b0;
            pkt_err <= 1'b0;
            if (take_b2 && pkt_good) begin
                wr_en         <= 1'b1;
                wr_addr       <= loc;
                wr_data       <= data;
                count_packets <= count_packets + 32'd1;
                if (pix_cnt != PIX_MAX) pix_cnt <= pix_cnt + 10'd1;
                if (pix_cnt == PIX_MAX - 10'd1) receive_done <= 1'b1;
            end else if ((take_b2 && !pkt_good) || timeout) begin
                pkt_err <= 1'b1;
                if (err_count != '1) err_count <= err_count + 1'b1;
            end
        end
    end

endmodule
